alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch.sv | 162 ++++++++++++++++
 tb/tb_alu_dispatch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// Instruction dispatcher: decodes, reads operands, issues to an external ALU,
// waits for the result with a timeout and writes it back to the register file.
module alu_dispatch #(
  parameter int DATA_W  = 19,
  parameter int NREGS   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic              alu_req_valid,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic              alu_rsp_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              ext_wr_en,
  input  logic [2:0]        ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              illegal_op,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [4:0] OP_NOT = 5'd0;
  localparam logic [4:0] OP_INC = 5'd8;
  localparam logic [4:0] OP_DEC = 5'd9;
  localparam logic [4:0] OP_MAX = 5'd9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        rd_q;
  logic [DATA_W-1:0] res_q;
  logic [4:0]        opcode_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic              req_q;
  logic              ill_q;
  logic              to_q;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [4:0]        f_op;
  logic [2:0]        f_rd;
  logic [2:0]        f_rs1;
  logic [2:0]        f_rs2;
  logic              legal;
  logic              no_op2;
  logic [DATA_W-1:0] op2_d;
  logic              unused_bits;

  assign f_op  = instr[DATA_W-1 -: 5];
  assign f_rd  = instr[DATA_W-6 -: 3];
  assign f_rs1 = instr[DATA_W-9 -: 3];
  assign f_rs2 = instr[DATA_W-12 -: 3];
  assign unused_bits = ^instr[DATA_W-15:0];

  assign legal = (f_op <= OP_MAX);

  always_comb begin
    no_op2 = 1'b0;
    unique case (1'b1)
      (f_op == OP_NOT): no_op2 = 1'b1;
      (f_op == OP_INC): no_op2 = 1'b1;
      (f_op == OP_DEC): no_op2 = 1'b1;
      default:          no_op2 = 1'b0;
    endcase
  end

  assign op2_d = no_op2 ? '0 : regs_q[f_rs2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      res_q    <= '0;
      opcode_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      req_q    <= 1'b0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      req_q <= 1'b0;
      ill_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (instr_valid) begin
            if (legal) begin
              opcode_q <= f_op;
              rd_q     <= f_rd;
              op1_q    <= regs_q[f_rs1];
              op2_q    <= op2_d;
              req_q    <= 1'b1;
              state_q  <= ISSUE;
            end else begin
              ill_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // a response on the last allowed cycle still wins over the timeout
          if (alu_rsp_valid) begin
            res_q   <= alu_result;
            state_q <= WB;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            to_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WB: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // writeback is ordered after the preload so it wins on an address clash
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (ext_wr_en) begin
        regs_q[ext_wr_addr] <= ext_wr_data;
      end
      if (state_q == WB) begin
        regs_q[rd_q] <= res_q;
      end
    end
  end

  assign instr_ready   = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign alu_req_valid = req_q;
  assign alu_opcode    = opcode_q;
  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign illegal_op    = ill_q;
  assign timeout_err   = to_q;
  assign dbg_data      = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed and randomized bench for alu_dispatch against a register-array
// model with an arithmetic reference ALU.
module tb_alu_dispatch;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [W-1:0] instr = '0;
  logic         alu_req_valid;
  logic [4:0]   alu_opcode;
  logic [W-1:0] alu_op1;
  logic [W-1:0] alu_op2;
  logic         alu_rsp_valid = 1'b0;
  logic [W-1:0] alu_result = '0;
  logic         ext_wr_en = 1'b0;
  logic [2:0]   ext_wr_addr = '0;
  logic [W-1:0] ext_wr_data = '0;
  logic [2:0]   dbg_addr = '0;
  logic [W-1:0] dbg_data;
  logic         busy;
  logic         illegal_op;
  logic         timeout_err;

  logic [W-1:0] mregs [8];
  bit           mto;
  int           vecs;
  int           errs;

  alu_dispatch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .alu_req_valid (alu_req_valid),
    .alu_opcode    (alu_opcode),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_rsp_valid (alu_rsp_valid),
    .alu_result    (alu_result),
    .ext_wr_en     (ext_wr_en),
    .ext_wr_addr   (ext_wr_addr),
    .ext_wr_data   (ext_wr_data),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .busy          (busy),
    .illegal_op    (illegal_op),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a,
                         input logic [W-1:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  task automatic chk_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk_reg(tag, 3'(i), mregs[i]);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [4:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      5'd0:    return ~a;
      5'd1:    return a & b;
      5'd2:    return a | b;
      5'd3:    return a ^ b;
      5'd4:    return W'(a + b);
      5'd5:    return W'(a - b);
      5'd6:    return W'(a * b);
      5'd7:    return (b == '0) ? '1 : W'(a / b);
      5'd8:    return W'(a + 1);
      5'd9:    return W'(a - 1);
      default: return '0;
    endcase
  endfunction

  task automatic ext_wr(input logic [2:0] a, input logic [W-1:0] d);
    ext_wr_en   = 1'b1;
    ext_wr_addr = a;
    ext_wr_data = d;
    step();
    ext_wr_en = 1'b0;
    mregs[a] = d;
  endtask

  task automatic do_op(input logic [4:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       input int dly, input bit byp, input bit col);
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    logic [W-1:0] res;
    logic [W-1:0] nv;
    e1  = mregs[rs1];
    e2  = (op == 5'd0 || op == 5'd8 || op == 5'd9) ? '0 : mregs[rs2];
    res = ref_alu(op, e1, e2);
    nv  = W'($urandom);
    chk("ready_before", 32'(instr_ready), 1);
    instr = {op, rd, rs1, rs2, 5'b0};
    instr_valid = 1'b1;
    if (byp) begin
      ext_wr_en   = 1'b1;
      ext_wr_addr = rs1;
      ext_wr_data = nv;
    end
    step();
    instr_valid = 1'b0;
    ext_wr_en   = 1'b0;
    if (byp) mregs[rs1] = nv;
    chk("req_issue", 32'(alu_req_valid), 1);
    chk("opcode", 32'(alu_opcode), 32'(op));
    chk("op1", 32'(alu_op1), 32'(e1));
    chk("op2", 32'(alu_op2), 32'(e2));
    chk("busy_issue", 32'(busy), 1);
    step();
    chk("req_pulse", 32'(alu_req_valid), 0);
    chk("op1_hold", 32'(alu_op1), 32'(e1));
    repeat (dly) step();
    chk("busy_wait", 32'(busy), 1);
    alu_rsp_valid = 1'b1;
    alu_result    = res;
    step();
    alu_rsp_valid = 1'b0;
    alu_result    = W'($urandom);
    chk("ready_wb", 32'(instr_ready), 0);
    if (col) begin
      ext_wr_en   = 1'b1;
      ext_wr_addr = rd;
      ext_wr_data = ~res;
    end
    step();
    ext_wr_en = 1'b0;
    mregs[rd] = res;
    chk("ready_after", 32'(instr_ready), 1);
    chk("timeout_flag", 32'(timeout_err), 32'(mto));
    chk_reg("wb_value", rd, res);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mto = 1'b0;

    #2;
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(alu_req_valid), 0);
    chk("rst_opcode", 32'(alu_opcode), 0);
    chk("rst_op1", 32'(alu_op1), 0);
    chk("rst_op2", 32'(alu_op2), 0);
    chk("rst_illegal", 32'(illegal_op), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk_all_regs("rst_regs");
    step();
    step();
    rst_n = 1'b1;
    step();

    // ADD r4 = r1 + r2 with the minimum-latency response
    ext_wr(3'd1, W'(5));
    ext_wr(3'd2, W'(3));
    do_op(5'd4, 3'd4, 3'd1, 3'd2, 0, 1'b0, 1'b0);

    // illegal opcode is consumed with a single pulse
    instr = {5'd12, 3'd3, 3'd1, 3'd2, 5'b0};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("ill_pulse", 32'(illegal_op), 1);
    chk("ill_noreq", 32'(alu_req_valid), 0);
    chk("ill_ready", 32'(instr_ready), 1);
    step();
    chk("ill_clear", 32'(illegal_op), 0);
    chk("ill_noreq2", 32'(alu_req_valid), 0);
    chk_all_regs("ill_regs");

    // INC wraps to zero, op2 forced to zero
    ext_wr(3'd1, W'(19'h7FFFF));
    do_op(5'd8, 3'd5, 3'd1, 3'd2, 1, 1'b0, 1'b0);

    // writeback collides with a preload to the same register
    do_op(5'd1, 3'd3, 3'd1, 3'd2, 2, 1'b0, 1'b1);

    // operand capture ignores a same-cycle preload of rs1
    do_op(5'd5, 3'd6, 3'd2, 3'd4, 0, 1'b1, 1'b0);

    // response on the very last WAIT cycle still writes back
    do_op(5'd3, 3'd7, 3'd4, 3'd6, 15, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        ext_wr(3'($urandom_range(0, 7)), W'($urandom));
      end
      do_op(5'($urandom_range(0, 9)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 15), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    // MUL with no response times out after 16 WAIT cycles
    instr = {5'd6, 3'd6, 3'd1, 3'd2, 5'b0};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("to_req", 32'(alu_req_valid), 1);
    repeat (16) step();
    chk("to_busy_last", 32'(busy), 1);
    chk("to_not_yet", 32'(timeout_err), 0);
    step();
    mto = 1'b1;
    chk("to_set", 32'(timeout_err), 1);
    chk("to_idle", 32'(instr_ready), 1);
    alu_rsp_valid = 1'b1;
    alu_result    = W'($urandom);
    step();
    alu_rsp_valid = 1'b0;
    chk("late_busy", 32'(busy), 0);
    step();
    chk_all_regs("to_regs");
    chk("to_sticky", 32'(timeout_err), 1);
    do_op(5'd2, 3'd0, 3'd3, 3'd5, 3, 1'b0, 1'b0);

    // reset in the middle of WAIT aborts everything
    instr = {5'd4, 3'd2, 3'd3, 3'd5, 5'b0};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mto = 1'b0;
    chk("ar_req", 32'(alu_req_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_opcode", 32'(alu_opcode), 0);
    chk("ar_op1", 32'(alu_op1), 0);
    chk("ar_op2", 32'(alu_op2), 0);
    chk("ar_timeout", 32'(timeout_err), 0);
    chk("ar_illegal", 32'(illegal_op), 0);
    instr = {5'd4, 3'd1, 3'd2, 3'd3, 5'b0};
    instr_valid = 1'b1;
    step();
    chk("ar_noaccept", 32'(busy), 0);
    instr_valid = 1'b0;
    rst_n = 1'b1;
    alu_rsp_valid = 1'b1;
    alu_result    = W'(19'h1234);
    step();
    alu_rsp_valid = 1'b0;
    chk("ar_late_busy", 32'(busy), 0);
    step();
    chk_all_regs("ar_regs");
    do_op(5'd9, 3'd1, 3'd0, 3'd7, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
